// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared constants and types for the UART/ALU packet controller.
// Opcode bytes, ALU operation encoding, controller state codes and the
// error response byte used when ALU_PACKET_CTRL_ERR_RESP_EN is defined.
package uart_alu_pkg;

    // Frame opcode bytes
    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD   = 8'h8A;
    localparam logic [7:0] OP_MUL   = 8'h88;
    localparam logic [7:0] OP_DIV   = 8'h89;

    // Single-byte response for aborted/invalid frames
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // ALU operation select (result is always the low 32 bits)
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_MUL = 2'd1,
        ALU_DIV = 2'd2
    } alu_op_e;

    // Controller state encoding
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_HDR_RSV   = 4'd1;
    localparam state_t ST_LEN_LO    = 4'd2;
    localparam state_t ST_LEN_HI    = 4'd3;
    localparam state_t ST_ECHO      = 4'd4;
    localparam state_t ST_OPND      = 4'd5;
    localparam state_t ST_ALU_REQ   = 4'd6;
    localparam state_t ST_ALU_WAIT  = 4'd7;
    localparam state_t ST_DRAIN     = 4'd8;
    localparam state_t ST_RESULT_TX = 4'd9;
    localparam state_t ST_ERR_TX    = 4'd10;

    function automatic logic is_arith(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic alu_op_e op_decode(input logic [7:0] op);
        case (op)
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/word_ser_le.sv
// word_ser_le: loads a 32-bit word and emits it as 4 bytes, least significant
// byte first, over a valid/ready byte handshake. valid_o drops after byte 3.
module word_ser_le (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o
);

    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    // Next state: load has priority, otherwise shift one byte per handshake
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shreg_d = word_i;
            cnt_d   = 2'd0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            shreg_d = {8'h00, shreg_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) valid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = shreg_q[7:0];
    assign valid_o = valid_q;
    assign last_o  = (cnt_q == 2'd3);

endmodule

// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: frame sequencer between the UART byte streams and the
// 32-bit ALU. Parses a 4-byte header (opcode, reserved, LE length), then
// echoes the payload or chains ALU operations over LE 32-bit operands and
// returns the 32-bit result as 4 bytes.
// Optional: ALU_PACKET_CTRL_ERR_RESP_EN makes invalid-opcode frames and
// timeout aborts answer with a single 0xEE byte; otherwise they are silent.
module alu_packet_ctrl
    import uart_alu_pkg::*;
#(
    parameter int          LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 31500000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    input  logic [31:0] alu_res_i,
    input  logic        alu_res_valid_i,
    output logic        busy_o
);

`ifdef ALU_PACKET_CTRL_ERR_RESP_EN
    localparam bit ERR_RESP = 1'b1;
`else
    localparam bit ERR_RESP = 1'b0;
`endif

    state_t         state_q, state_d;
    logic [7:0]     opcode_q, opcode_d;
    logic [7:0]     len_lo_q, len_lo_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]    opnd_q, opnd_d;
    logic [1:0]     bcnt_q, bcnt_d;
    logic           have_acc_q, have_acc_d;
    logic [31:0]    acc_q, acc_d;
    logic [7:0]     txb_q, txb_d;
    logic           txv_q, txv_d;
    logic           alu_v_q, alu_v_d;
    logic [31:0]    alu_a_q, alu_a_d;
    logic [31:0]    alu_b_q, alu_b_d;
    alu_op_e        alu_op_q, alu_op_d;
    logic [31:0]    tmo_q, tmo_d;

    logic           rx_ready, rx_fire, tx_fire;
    logic [15:0]    len16;
    logic [31:0]    word_full;
    logic [LEN_W-1:0] rem_dec;
    logic           timed, tmo_hit;
    logic           ser_load, ser_valid, ser_last;
    logic [7:0]     ser_data;

    // Byte acceptance: header/operand/drain states always, echo only when the
    // one-byte tx buffer is empty.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_HDR_RSV, ST_LEN_LO, ST_LEN_HI,
            ST_OPND, ST_DRAIN:  rx_ready = 1'b1;
            ST_ECHO:            rx_ready = !txv_q;
            default:            rx_ready = 1'b0;
        endcase
    end

    assign rx_fire   = rx_valid_i && rx_ready;
    assign tx_fire   = txv_q && tx_ready_i;
    assign len16     = {rx_data_i, len_lo_q};
    assign word_full = {rx_data_i, opnd_q[31:8]};
    assign rem_dec   = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;

    // Inactivity timer runs only while waiting on the host for bytes
    assign timed   = (state_q == ST_HDR_RSV) || (state_q == ST_LEN_LO) ||
                     (state_q == ST_LEN_HI)  || (state_q == ST_ECHO)   ||
                     (state_q == ST_OPND)    || (state_q == ST_DRAIN);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && timed && !rx_fire &&
                     (tmo_q == TIMEOUT_CYCLES - 1);

    // Main sequencer next-state logic
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        opnd_d     = opnd_q;
        bcnt_d     = bcnt_q;
        have_acc_d = have_acc_q;
        acc_d      = acc_q;
        txb_d      = txb_q;
        txv_d      = txv_q;
        alu_v_d    = alu_v_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tmo_d      = (TIMEOUT_CYCLES != 0 && timed && !rx_fire) ? tmo_q + 32'd1 : 32'd0;

        case (state_q)
            ST_IDLE: if (rx_fire) begin
                opcode_d   = rx_data_i;
                have_acc_d = 1'b0;
                bcnt_d     = 2'd0;
                state_d    = ST_HDR_RSV;
            end
            ST_HDR_RSV: if (rx_fire) state_d = ST_LEN_LO;
            ST_LEN_LO: if (rx_fire) begin
                len_lo_d = rx_data_i;
                state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: if (rx_fire) begin
                if (len16 <= 16'd4) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d    = LEN_W'(len16 - 16'd4);
                    alu_op_d = op_decode(opcode_q);
                    if (opcode_q == OP_ECHO)     state_d = ST_ECHO;
                    // fewer than 4 payload bytes: no operand, drain silently
                    else if (is_arith(opcode_q)) state_d = (len16 < 16'd8) ? ST_DRAIN : ST_OPND;
                    else                         state_d = ST_DRAIN;
                end
            end
            ST_ECHO: begin
                if (rx_fire) begin
                    txb_d = rx_data_i;
                    txv_d = 1'b1;
                    rem_d = rem_dec;
                end else if (tx_fire) begin
                    txv_d = 1'b0;
                    if (rem_q == '0) state_d = ST_IDLE;
                end
            end
            ST_OPND: if (rx_fire) begin
                rem_d  = rem_dec;
                opnd_d = word_full;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    if (!have_acc_q) begin
                        // first operand seeds the accumulator without an ALU call
                        acc_d      = word_full;
                        have_acc_d = 1'b1;
                        if (rem_dec == '0)             state_d = ST_RESULT_TX;
                        else if (rem_dec < LEN_W'(4))  state_d = ST_DRAIN;
                    end else begin
                        alu_a_d = acc_q;
                        alu_b_d = word_full;
                        alu_v_d = 1'b1;
                        state_d = ST_ALU_REQ;
                    end
                end
            end
            ST_ALU_REQ: if (alu_ready_i) begin
                alu_v_d = 1'b0;
                state_d = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: if (alu_res_valid_i) begin
                acc_d = alu_res_i;
                if (rem_q == '0)             state_d = ST_RESULT_TX;
                else if (rem_q < LEN_W'(4))  state_d = ST_DRAIN;
                else                         state_d = ST_OPND;
            end
            ST_DRAIN: if (rx_fire) begin
                rem_d = rem_dec;
                if (rem_dec == '0) begin
                    if (have_acc_q) begin
                        state_d = ST_RESULT_TX;
                    end else if (ERR_RESP && !is_arith(opcode_q)) begin
                        txb_d   = ERR_BYTE;
                        txv_d   = 1'b1;
                        state_d = ST_ERR_TX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESULT_TX: if (ser_valid && tx_ready_i && ser_last) state_d = ST_IDLE;
            ST_ERR_TX: if (tx_fire) begin
                txv_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout abort discards the frame, including any pending echo byte
        if (tmo_hit) begin
            acc_d      = '0;
            have_acc_d = 1'b0;
            txv_d      = 1'b0;
            state_d    = ST_IDLE;
            if (ERR_RESP) begin
                txb_d   = ERR_BYTE;
                txv_d   = 1'b1;
                state_d = ST_ERR_TX;
            end
        end
    end

    // Kick the serializer on entry to RESULT_TX with the final accumulator
    assign ser_load = (state_d == ST_RESULT_TX) && (state_q != ST_RESULT_TX);

    word_ser_le u_ser (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (ser_load),
        .word_i  (acc_d),
        .data_o  (ser_data),
        .valid_o (ser_valid),
        .ready_i (tx_ready_i),
        .last_o  (ser_last)
    );

    // Controller registers, all cleared asynchronously
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            opnd_q     <= '0;
            bcnt_q     <= '0;
            have_acc_q <= 1'b0;
            acc_q      <= '0;
            txb_q      <= '0;
            txv_q      <= 1'b0;
            alu_v_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= ALU_ADD;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            opnd_q     <= opnd_d;
            bcnt_q     <= bcnt_d;
            have_acc_q <= have_acc_d;
            acc_q      <= acc_d;
            txb_q      <= txb_d;
            txv_q      <= txv_d;
            alu_v_q    <= alu_v_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tmo_q      <= tmo_d;
        end
    end

    assign rx_ready_o  = rx_ready;
    assign tx_valid_o  = txv_q | ser_valid;
    assign tx_data_o   = ser_valid ? ser_data : txb_q;
    assign alu_valid_o = alu_v_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
